// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle sequencer for the MIPS-subset datapath (ADDU/SUBU/AND/OR/SLT,
//   ORI, LW, SW, BEQ, J, ADDI, LUI). Each instruction walks the FSM through
//   fetch, decode, execute, an optional memory access and writeback. Instruction
//   fetch and data access share one memory port through a mem_req/mem_ready
//   handshake.
//
// Ports
//   clk, reset   rising-edge clock, synchronous active-high reset
//   op, func     IR[31:26] and IR[5:0]; only looked at in DECODE
//   zero         ALU zero flag for BEQ
//   mem_ready    memory finishes the current access this cycle
//   mem_req      memory request, held until mem_ready
//   PCWrite      PC load enable; npcctrol selects the next-PC source
//   IRWrite      instruction register load enable
//   RegWrite     register file write enable
//   ALUsrc       0 = rt data, 1 = extended immediate
//   RegDst       0 = rt, 1 = rd
//   MemWrite     write qualifier for mem_req
//   MemToReg     00 ALU, 01 memory, 10 lui immediate
//   npcctrol     00 PC+4, 01 jump target, 10 branch target
//   ExtOp        00 zero-ext, 01 sign-ext, 10 upper
//   ALUctr       000 ADD, 001 SUB, 010 OR, 011 AND, 111 SLT
//   instr_done   pulse on the last cycle of every instruction
//   illegal_op   pulse in DECODE for an unknown op/func
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUsrc,
  output logic       RegDst,
  output logic       MemWrite,
  output logic [1:0] MemToReg,
  output logic [1:0] npcctrol,
  output logic [1:0] ExtOp,
  output logic [2:0] ALUctr,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, BRANCH, JUMP
  } state_t;

  state_t     state, next_state;
  logic [5:0] op_q, func_q;

  logic       op_known, func_known;
  logic       exec_alusrc, exec_regdst;
  logic [1:0] exec_ext;
  logic [2:0] exec_alu;

  // State register; op/func are captured only in DECODE so later IR-bus
  // activity cannot disturb an instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      op_q   <= '0;
      func_q <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE) begin
        op_q   <= op;
        func_q <= func;
      end
    end
  end

  // Legality check on the live IR fields, used in DECODE only.
  always_comb begin
    op_known   = 1'b0;
    func_known = 1'b0;
    case (func)
      FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: func_known = 1'b1;
      default:                                 func_known = 1'b0;
    endcase
    case (op)
      OP_RTYPE:                                          op_known = func_known;
      OP_J, OP_BEQ, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW: op_known = 1'b1;
      default:                                           op_known = 1'b0;
    endcase
  end

  // Execute-phase datapath controls from the latched instruction. WB reuses
  // them so the ALU result stays valid while the register file is written.
  always_comb begin
    exec_alusrc = 1'b0;
    exec_regdst = 1'b0;
    exec_ext    = 2'b00;
    exec_alu    = 3'b000;
    case (op_q)
      OP_RTYPE: begin
        exec_regdst = 1'b1;
        case (func_q)
          FN_SUBU: exec_alu = 3'b001;
          FN_AND:  exec_alu = 3'b011;
          FN_OR:   exec_alu = 3'b010;
          FN_SLT:  exec_alu = 3'b111;
          default: exec_alu = 3'b000;
        endcase
      end
      OP_ORI: begin
        exec_alusrc = 1'b1;
        exec_alu    = 3'b010;
      end
      OP_ADDI, OP_LW, OP_SW: begin
        exec_alusrc = 1'b1;
        exec_ext    = 2'b01;
      end
      default: ;
    endcase
  end

  // Next-state and Moore outputs. Reset overrides every output last so no
  // strobe escapes during a reset cycle, even mid memory wait.
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUsrc     = 1'b0;
    RegDst     = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = 2'b00;
    npcctrol   = 2'b00;
    ExtOp      = 2'b00;
    ALUctr     = 3'b000;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        if (!op_known) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
          next_state = FETCH;
        end else begin
          case (op)
            OP_BEQ:  next_state = BRANCH;
            OP_J:    next_state = JUMP;
            OP_LUI:  next_state = WB;
            default: next_state = EXEC;
          endcase
        end
      end
      EXEC: begin
        ALUsrc = exec_alusrc;
        RegDst = exec_regdst;
        ExtOp  = exec_ext;
        ALUctr = exec_alu;
        case (op_q)
          OP_LW:   next_state = MEM_RD;
          OP_SW:   next_state = MEM_WR;
          default: next_state = WB;
        endcase
      end
      MEM_RD: begin
        mem_req = 1'b1;
        ALUsrc  = 1'b1;
        ExtOp   = 2'b01;
        if (mem_ready) next_state = WB;
      end
      MEM_WR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        ALUsrc   = 1'b1;
        ExtOp    = 2'b01;
        if (mem_ready) begin
          instr_done = 1'b1;
          next_state = FETCH;
        end
      end
      WB: begin
        RegWrite   = 1'b1;
        ALUsrc     = exec_alusrc;
        RegDst     = exec_regdst;
        ExtOp      = exec_ext;
        ALUctr     = exec_alu;
        instr_done = 1'b1;
        if (op_q == OP_LW) begin
          MemToReg = 2'b01;
        end else if (op_q == OP_LUI) begin
          MemToReg = 2'b10;
          ExtOp    = 2'b10;
        end
        next_state = FETCH;
      end
      BRANCH: begin
        ALUctr     = 3'b001;
        instr_done = 1'b1;
        if (zero) begin
          PCWrite  = 1'b1;
          npcctrol = 2'b10;
        end
        next_state = FETCH;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        npcctrol   = 2'b01;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase

    if (reset) begin
      mem_req    = 1'b0;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUsrc     = 1'b0;
      RegDst     = 1'b0;
      MemWrite   = 1'b0;
      MemToReg   = 2'b00;
      npcctrol   = 2'b00;
      ExtOp      = 2'b00;
      ALUctr     = 3'b000;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. Each step drives the inputs for one
//   clock cycle and compares the whole output bundle against a hand-written
//   expectation built with e().
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] op, func;
  logic       zero, mem_ready;
  logic       mem_req, PCWrite, IRWrite, RegWrite, ALUsrc, RegDst, MemWrite;
  logic [1:0] MemToReg, npcctrol, ExtOp;
  logic [2:0] ALUctr;
  logic       instr_done, illegal_op;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_NONE = 6'b000000;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .func       (func),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ALUsrc     (ALUsrc),
    .RegDst     (RegDst),
    .MemWrite   (MemWrite),
    .MemToReg   (MemToReg),
    .npcctrol   (npcctrol),
    .ExtOp      (ExtOp),
    .ALUctr     (ALUctr),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bundle layout: mem_req PCWrite IRWrite RegWrite ALUsrc RegDst MemWrite
  // MemToReg[2] npcctrol[2] ExtOp[2] ALUctr[3] instr_done illegal_op
  function automatic logic [17:0] e(input logic mreq, pcw, irw, rw, asrc, rdst, mw,
                                    input logic [1:0] m2r, npc, ext,
                                    input logic [2:0] alu,
                                    input logic done, ill);
    return {mreq, pcw, irw, rw, asrc, rdst, mw, m2r, npc, ext, alu, done, ill};
  endfunction

  localparam logic [17:0] ZERO   = 18'd0;
  localparam logic [17:0] F_GO   = 18'b1_1_1_0_0_0_0_00_00_00_000_0_0;
  localparam logic [17:0] F_WAIT = 18'b1_0_0_0_0_0_0_00_00_00_000_0_0;

  task automatic applyStimulus(input logic rst, input logic [5:0] o, f,
                               input logic z, rdy);
    reset     = rst;
    op        = o;
    func      = f;
    zero      = z;
    mem_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [17:0] expv);
    logic [17:0] obs;
    obs = {mem_req, PCWrite, IRWrite, RegWrite, ALUsrc, RegDst, MemWrite,
           MemToReg, npcctrol, ExtOp, ALUctr, instr_done, illegal_op};
    compared++;
    assert (obs === expv)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b required %b", tag, obs, expv);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are sampled
  // one unit later, well clear of both clock edges.
  task automatic runCycle(input string tag, input logic rst,
                          input logic [5:0] o, f, input logic z, rdy,
                          input logic [17:0] expv);
    applyStimulus(rst, o, f, z, rdy);
    #1;
    checkOutput(tag, expv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b1, OP_R, FN_NONE, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    runCycle("reset_quiet", 1'b1, OP_R, FN_NONE, 1'b0, 1'b1, ZERO);

    // ADDU: F, D, E, WB; op bus scrambled after DECODE must not matter
    runCycle("addu_fetch",  1'b0, OP_R,   FN_ADDU, 1'b0, 1'b1, F_GO);
    runCycle("addu_decode", 1'b0, OP_R,   FN_ADDU, 1'b0, 1'b1, ZERO);
    runCycle("addu_exec",   1'b0, OP_BAD, FN_NONE, 1'b0, 1'b1,
             e(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b000,0,0));
    runCycle("addu_wb",     1'b0, OP_LW,  FN_NONE, 1'b0, 1'b1,
             e(0,0,0,1,0,1,0,2'b00,2'b00,2'b00,3'b000,1,0));

    // SLT
    runCycle("slt_fetch",  1'b0, OP_R, FN_SLT, 1'b0, 1'b1, F_GO);
    runCycle("slt_decode", 1'b0, OP_R, FN_SLT, 1'b0, 1'b1, ZERO);
    runCycle("slt_exec",   1'b0, OP_R, FN_SLT, 1'b0, 1'b1,
             e(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b111,0,0));
    runCycle("slt_wb",     1'b0, OP_R, FN_SLT, 1'b0, 1'b1,
             e(0,0,0,1,0,1,0,2'b00,2'b00,2'b00,3'b111,1,0));

    // LW with three wait cycles in MEM_RD: 8 cycles total
    runCycle("lw_fetch",  1'b0, OP_LW, FN_NONE, 1'b0, 1'b1, F_GO);
    runCycle("lw_decode", 1'b0, OP_LW, FN_NONE, 1'b0, 1'b1, ZERO);
    runCycle("lw_exec",   1'b0, OP_LW, FN_NONE, 1'b0, 1'b1,
             e(0,0,0,0,1,0,0,2'b00,2'b00,2'b01,3'b000,0,0));
    for (int i = 0; i < 3; i++)
      runCycle("lw_memrd_wait", 1'b0, OP_LW, FN_NONE, 1'b0, 1'b0,
               e(1,0,0,0,1,0,0,2'b00,2'b00,2'b01,3'b000,0,0));
    runCycle("lw_memrd_ready", 1'b0, OP_LW, FN_NONE, 1'b0, 1'b1,
             e(1,0,0,0,1,0,0,2'b00,2'b00,2'b01,3'b000,0,0));
    runCycle("lw_wb",     1'b0, OP_LW, FN_NONE, 1'b0, 1'b1,
             e(0,0,0,1,1,0,0,2'b01,2'b00,2'b01,3'b000,1,0));

    // BEQ taken and not taken
    runCycle("beqt_fetch",  1'b0, OP_BEQ, FN_NONE, 1'b1, 1'b1, F_GO);
    runCycle("beqt_decode", 1'b0, OP_BEQ, FN_NONE, 1'b1, 1'b1, ZERO);
    runCycle("beqt_branch", 1'b0, OP_BEQ, FN_NONE, 1'b1, 1'b1,
             e(0,1,0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,1,0));
    runCycle("beqn_fetch",  1'b0, OP_BEQ, FN_NONE, 1'b0, 1'b1, F_GO);
    runCycle("beqn_decode", 1'b0, OP_BEQ, FN_NONE, 1'b0, 1'b1, ZERO);
    runCycle("beqn_branch", 1'b0, OP_BEQ, FN_NONE, 1'b0, 1'b1,
             e(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b001,1,0));

    // Illegal op, then a fetch that has to wait, then an illegal R-type func
    runCycle("ill_op_fetch",    1'b0, OP_BAD, FN_NONE, 1'b0, 1'b1, F_GO);
    runCycle("ill_op_decode",   1'b0, OP_BAD, FN_NONE, 1'b0, 1'b1,
             e(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,1));
    runCycle("ill_fetch_wait",  1'b0, OP_BAD, FN_NONE, 1'b0, 1'b0, F_WAIT);
    runCycle("ill_fn_fetch",    1'b0, OP_R,   FN_NONE, 1'b0, 1'b1, F_GO);
    runCycle("ill_fn_decode",   1'b0, OP_R,   FN_NONE, 1'b0, 1'b1,
             e(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,1));

    // ORI
    runCycle("ori_fetch",  1'b0, OP_ORI, FN_NONE, 1'b0, 1'b1, F_GO);
    runCycle("ori_decode", 1'b0, OP_ORI, FN_NONE, 1'b0, 1'b1, ZERO);
    runCycle("ori_exec",   1'b0, OP_ORI, FN_NONE, 1'b0, 1'b1,
             e(0,0,0,0,1,0,0,2'b00,2'b00,2'b00,3'b010,0,0));
    runCycle("ori_wb",     1'b0, OP_ORI, FN_NONE, 1'b0, 1'b1,
             e(0,0,0,1,1,0,0,2'b00,2'b00,2'b00,3'b010,1,0));

    // SW interrupted by reset while the memory write is still pending
    runCycle("swr_fetch",  1'b0, OP_SW, FN_NONE, 1'b0, 1'b1, F_GO);
    runCycle("swr_decode", 1'b0, OP_SW, FN_NONE, 1'b0, 1'b1, ZERO);
    runCycle("swr_exec",   1'b0, OP_SW, FN_NONE, 1'b0, 1'b1,
             e(0,0,0,0,1,0,0,2'b00,2'b00,2'b01,3'b000,0,0));
    runCycle("swr_memwr_wait", 1'b0, OP_SW, FN_NONE, 1'b0, 1'b0,
             e(1,0,0,0,1,0,1,2'b00,2'b00,2'b01,3'b000,0,0));
    runCycle("swr_reset",      1'b1, OP_SW, FN_NONE, 1'b0, 1'b0, ZERO);
    runCycle("swr_after_rst",  1'b0, OP_SW, FN_NONE, 1'b0, 1'b0, F_WAIT);

    // Back-to-back J, SW, LUI: instr_done at cycles 3, 7 and 10
    runCycle("j_fetch",    1'b0, OP_J,   FN_NONE, 1'b0, 1'b1, F_GO);
    runCycle("j_decode",   1'b0, OP_J,   FN_NONE, 1'b0, 1'b1, ZERO);
    runCycle("j_jump",     1'b0, OP_J,   FN_NONE, 1'b0, 1'b1,
             e(0,1,0,0,0,0,0,2'b00,2'b01,2'b00,3'b000,1,0));
    runCycle("sw_fetch",   1'b0, OP_SW,  FN_NONE, 1'b0, 1'b1, F_GO);
    runCycle("sw_decode",  1'b0, OP_SW,  FN_NONE, 1'b0, 1'b1, ZERO);
    runCycle("sw_exec",    1'b0, OP_SW,  FN_NONE, 1'b0, 1'b1,
             e(0,0,0,0,1,0,0,2'b00,2'b00,2'b01,3'b000,0,0));
    runCycle("sw_memwr",   1'b0, OP_SW,  FN_NONE, 1'b0, 1'b1,
             e(1,0,0,0,1,0,1,2'b00,2'b00,2'b01,3'b000,1,0));
    runCycle("lui_fetch",  1'b0, OP_LUI, FN_NONE, 1'b0, 1'b1, F_GO);
    runCycle("lui_decode", 1'b0, OP_LUI, FN_NONE, 1'b0, 1'b1, ZERO);
    runCycle("lui_wb",     1'b0, OP_LUI, FN_NONE, 1'b0, 1'b1,
             e(0,0,0,1,0,0,0,2'b10,2'b00,2'b10,3'b000,1,0));
    runCycle("next_fetch", 1'b0, OP_R,   FN_NONE, 1'b0, 1'b0, F_WAIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
